ppu_bg_fetch_sequencer: RTL and testbench
=========================================

PPU_BG_FETCH_SEQUENCER -- requirements
Module: ppu_bg_fetch_sequencer

Interface
REQ-001 SHALL have parameter FETCH_CYCLES, default 2, meaning cycles spent on each of the four fetches (legal 1..4).
REQ-002 SHALL have parameter NT_BASE, default 14'h2000, meaning the nametable region base; attribute base is NT_BASE|14'h03C0.
REQ-003 SHALL have port i_clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port i_reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_enable  in  1  background fetch window active.
REQ-006 SHALL have port i_v  in  15  loopy v: [14:12] fineY, [11:10] nametable, [9:5] coarseY, [4:0] coarseX.
REQ-007 SHALL have port i_bg_table  in  1  background pattern table select (PPUCTRL bit 4).
REQ-008 SHALL have port i_data  in  8  PPU bus read data.
REQ-009 SHALL have port o_address  out  14  PPU bus address of the current fetch.
REQ-010 SHALL have port o_rd  out  1  high while a fetch is in progress.
REQ-011 SHALL have port o_fetch  out  2  current fetch: 0 NT, 1 AT, 2 PT_LO, 3 PT_HI (0 when idle).
REQ-012 SHALL have port o_pattern_lo / o_pattern_hi  out  8 each  completed tile pattern bytes.
REQ-013 SHALL have port o_palette  out  2  completed tile 2-bit attribute.
REQ-014 SHALL have port o_tile_done  out  1  one-cycle pulse when a tile's four fetches complete.

Function
REQ-015 SHALL implement states IDLE, NT, AT, PT_LO, PT_HI and a phase counter 0..FETCH_CYCLES-1.
REQ-016 SHALL, in IDLE with i_enable high at a clock edge, enter NT with phase 0 and latch i_v into an internal tile v register.
REQ-017 SHALL hold each fetch state exactly FETCH_CYCLES cycles; at the edge ending the last phase, capture i_data and advance NT->AT->PT_LO->PT_HI.
REQ-018 SHALL derive o_address combinationally from state and latched v only (not live i_v).
REQ-019 SHALL drive NT address = NT_BASE | v[11:0].
REQ-020 SHALL drive AT address = NT_BASE | 14'h03C0 | {v[11:10],4'b0000,v[9:7],v[4:2]} (nametable select at bits 11:10).
REQ-021 SHALL drive PT_LO address = {1'b0, i_bg_table, nt_byte[7:0], 1'b0, v[14:12]}; PT_HI = PT_LO | 14'h0008.
REQ-022 SHALL drive o_address = 0, o_rd = 0, o_fetch = 0 in IDLE.
REQ-023 SHALL compute palette = (at_byte >> {v[6], v[1], 1'b0}) & 2'b11 from latched v.
REQ-024 SHALL, at the edge ending PT_HI, update o_pattern_lo (captured PT_LO byte), o_pattern_hi (i_data), o_palette together, and assert o_tile_done for the following cycle only.
REQ-025 SHALL, at that same edge, go to NT latching new i_v if i_enable is high (back-to-back tiles, period 4*FETCH_CYCLES, no gap), else IDLE.
REQ-026 SHALL, if i_enable is low at any edge in NT/AT/PT_LO/PT_HI other than the PT_HI completion edge, abort to IDLE with no o_tile_done and unchanged tile outputs.
REQ-027 SHALL treat the PT_HI completion edge as completing the tile regardless of i_enable.
REQ-028 SHALL ignore i_v changes during a tile; only the NT-entry sample matters.
REQ-029 SHALL, with FETCH_CYCLES=1, advance state every cycle with identical ordering.

Reset
REQ-030 SHALL, on i_reset_n low, asynchronously force state IDLE, phase 0, all internal bytes 0, o_pattern_lo=0, o_pattern_hi=0, o_palette=0, o_tile_done=0, o_rd=0, o_address=0.
REQ-031 SHALL, on reset mid-tile, discard the partial tile; first tile after release starts on the first edge with i_enable high.

Verification
REQ-032 SHALL cover single tile: FETCH_CYCLES=2, i_v=15'h34AA, i_bg_table=1, data NT=8'h5C, AT=8'hE4, PT_LO=8'hA5, PT_HI=8'h3C -> addresses 14'h24AA, 14'h27CA, 14'h15C3, 14'h15CB each held 2 cycles; o_pattern_lo=A5, o_pattern_hi=3C, o_palette=1, one o_tile_done pulse 8 cycles after start.
REQ-033 SHALL cover quadrant select: AT byte 8'hE4 with (coarseY,coarseX) bit1 = (0,0),(0,1),(1,0),(1,1) -> o_palette 0,1,2,3.
REQ-034 SHALL cover back-to-back: i_enable held 32 cycles -> four o_tile_done pulses exactly 8 cycles apart, each NT fetch using i_v sampled at its start.
REQ-035 SHALL cover abort: i_enable dropped during AT -> IDLE next edge, o_rd=0, no o_tile_done, tile outputs unchanged.
REQ-036 SHALL cover reset mid-PT_LO -> all outputs 0 immediately (asynchronous, before next edge); next tile after release behaves as REQ-032.
REQ-037 SHALL cover FETCH_CYCLES=1, i_v=15'h0000, i_bg_table=0, NT byte 8'hFF -> addresses 14'h2000, 14'h23C0, 14'h0FF0, 14'h0FF8 on consecutive cycles, o_tile_done 4 cycles after start.

Source files
------------

// File: rtl/ppu_bg_fetch_sequencer_if.sv
// PPU bus between the background fetch sequencer (master) and VRAM (slave).
interface ppu_bg_fetch_sequencer_if;
  logic [13:0] o_address;
  logic        o_rd;
  logic [1:0]  o_fetch;
  logic [7:0]  i_data;

  modport master (
    output o_address,
    output o_rd,
    output o_fetch,
    input  i_data
  );

  modport slave (
    input  o_address,
    input  o_rd,
    input  o_fetch,
    output i_data
  );
endinterface

// File: rtl/ppu_bg_fetch_sequencer.sv
// Background tile fetch sequencer: NT -> AT -> PT_LO -> PT_HI, each fetch
// held FETCH_CYCLES cycles, producing one tile's pattern bytes and palette.
module ppu_bg_fetch_sequencer #(
  parameter int          FETCH_CYCLES = 2,
  parameter logic [13:0] NT_BASE      = 14'h2000
) (
  input  logic                            i_clk,
  input  logic                            i_reset_n,
  input  logic                            i_enable,
  input  logic [14:0]                     i_v,
  input  logic                            i_bg_table,
  ppu_bg_fetch_sequencer_if.master        bus,
  output logic [7:0]                      o_pattern_lo,
  output logic [7:0]                      o_pattern_hi,
  output logic [1:0]                      o_palette,
  output logic                            o_tile_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NT    = 3'd1,
    S_AT    = 3'd2,
    S_PT_LO = 3'd3,
    S_PT_HI = 3'd4
  } state_t;

  localparam int            PW         = (FETCH_CYCLES > 1) ? $clog2(FETCH_CYCLES) : 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(FETCH_CYCLES - 1);
  localparam logic [13:0]   AT_BASE    = NT_BASE | 14'h03C0;

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [14:0]   v_q, v_d;
  logic [7:0]    nt_q, nt_d;
  logic [7:0]    at_q, at_d;
  logic [7:0]    pt_lo_q, pt_lo_d;
  logic [7:0]    pattern_lo_q, pattern_lo_d;
  logic [7:0]    pattern_hi_q, pattern_hi_d;
  logic [1:0]    palette_q, palette_d;
  logic          tile_done_q, tile_done_d;

  logic          last_phase;
  logic [2:0]    pal_shift;
  logic [7:0]    at_shifted;

  assign last_phase = (phase_q == LAST_PHASE);
  // Quadrant within the 32x32 attribute area picks one 2-bit field of the AT byte.
  assign pal_shift  = {v_q[6], v_q[1], 1'b0};
  assign at_shifted = at_q >> pal_shift;

  // State and data registers; reset clears any partial tile.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      v_q          <= '0;
      nt_q         <= '0;
      at_q         <= '0;
      pt_lo_q      <= '0;
      pattern_lo_q <= '0;
      pattern_hi_q <= '0;
      palette_q    <= '0;
      tile_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      v_q          <= v_d;
      nt_q         <= nt_d;
      at_q         <= at_d;
      pt_lo_q      <= pt_lo_d;
      pattern_lo_q <= pattern_lo_d;
      pattern_hi_q <= pattern_hi_d;
      palette_q    <= palette_d;
      tile_done_q  <= tile_done_d;
    end
  end

  // Next-state: phase counting, fetch capture, abort on enable drop, tile completion.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    v_d          = v_q;
    nt_d         = nt_q;
    at_d         = at_q;
    pt_lo_d      = pt_lo_q;
    pattern_lo_d = pattern_lo_q;
    pattern_hi_d = pattern_hi_q;
    palette_d    = palette_q;
    tile_done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_enable) begin
          state_d = S_NT;
          phase_d = '0;
          v_d     = i_v;
        end
      end

      S_NT, S_AT, S_PT_LO: begin
        if (!i_enable) begin
          state_d = S_IDLE;
          phase_d = '0;
        end else if (last_phase) begin
          phase_d = '0;
          case (state_q)
            S_NT: begin
              nt_d    = bus.i_data;
              state_d = S_AT;
            end
            S_AT: begin
              at_d    = bus.i_data;
              state_d = S_PT_LO;
            end
            default: begin
              pt_lo_d = bus.i_data;
              state_d = S_PT_HI;
            end
          endcase
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      S_PT_HI: begin
        // The completion edge finishes the tile even if enable has just dropped.
        if (last_phase) begin
          pattern_lo_d = pt_lo_q;
          pattern_hi_d = bus.i_data;
          palette_d    = at_shifted[1:0];
          tile_done_d  = 1'b1;
          phase_d      = '0;
          if (i_enable) begin
            state_d = S_NT;
            v_d     = i_v;
          end else begin
            state_d = S_IDLE;
          end
        end else if (!i_enable) begin
          state_d = S_IDLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        phase_d = '0;
      end
    endcase
  end

  // Bus outputs decoded from the state and the tile's latched v only.
  always_comb begin
    bus.o_address = '0;
    bus.o_rd      = 1'b0;
    bus.o_fetch   = 2'd0;
    case (state_q)
      S_NT: begin
        bus.o_address = NT_BASE | {2'b00, v_q[11:0]};
        bus.o_rd      = 1'b1;
        bus.o_fetch   = 2'd0;
      end
      S_AT: begin
        bus.o_address = AT_BASE | {2'b00, v_q[11:10], 4'b0000, v_q[9:7], v_q[4:2]};
        bus.o_rd      = 1'b1;
        bus.o_fetch   = 2'd1;
      end
      S_PT_LO: begin
        bus.o_address = {1'b0, i_bg_table, nt_q, 1'b0, v_q[14:12]};
        bus.o_rd      = 1'b1;
        bus.o_fetch   = 2'd2;
      end
      S_PT_HI: begin
        bus.o_address = {1'b0, i_bg_table, nt_q, 1'b1, v_q[14:12]};
        bus.o_rd      = 1'b1;
        bus.o_fetch   = 2'd3;
      end
      default: begin
        bus.o_address = '0;
        bus.o_rd      = 1'b0;
        bus.o_fetch   = 2'd0;
      end
    endcase
  end

  assign o_pattern_lo = pattern_lo_q;
  assign o_pattern_hi = pattern_hi_q;
  assign o_palette    = palette_q;
  assign o_tile_done  = tile_done_q;

endmodule

// File: tb/tb_ppu_bg_fetch_sequencer.sv
// Bench for ppu_bg_fetch_sequencer: two instances (FETCH_CYCLES 2 and 1),
// checked cycle by cycle against a tile-level reference model.
module tb_ppu_bg_fetch_sequencer;
  localparam int NT_BASE_I = 'h2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        enable;
  logic [14:0] v;
  logic        bg;
  logic [7:0]  data;

  ppu_bg_fetch_sequencer_if bus_a ();
  ppu_bg_fetch_sequencer_if bus_b ();
  assign bus_a.i_data = data;
  assign bus_b.i_data = data;

  logic [7:0] a_lo, a_hi, b_lo, b_hi;
  logic [1:0] a_pal, b_pal;
  logic       a_done, b_done;

  ppu_bg_fetch_sequencer #(.FETCH_CYCLES(2), .NT_BASE(14'h2000)) dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(enable), .i_v(v), .i_bg_table(bg),
    .bus(bus_a.master), .o_pattern_lo(a_lo), .o_pattern_hi(a_hi),
    .o_palette(a_pal), .o_tile_done(a_done)
  );

  ppu_bg_fetch_sequencer #(.FETCH_CYCLES(1), .NT_BASE(14'h2000)) dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(enable), .i_v(v), .i_bg_table(bg),
    .bus(bus_b.master), .o_pattern_lo(b_lo), .o_pattern_hi(b_hi),
    .o_palette(b_pal), .o_tile_done(b_done)
  );

  // Observation selects the instance under test.
  logic        sel_b;
  int          fc;
  logic [13:0] obs_addr;
  logic        obs_rd, obs_done;
  logic [1:0]  obs_fetch, obs_pal;
  logic [7:0]  obs_lo, obs_hi;
  assign obs_addr  = sel_b ? bus_b.o_address : bus_a.o_address;
  assign obs_rd    = sel_b ? bus_b.o_rd      : bus_a.o_rd;
  assign obs_fetch = sel_b ? bus_b.o_fetch   : bus_a.o_fetch;
  assign obs_lo    = sel_b ? b_lo   : a_lo;
  assign obs_hi    = sel_b ? b_hi   : a_hi;
  assign obs_pal   = sel_b ? b_pal  : a_pal;
  assign obs_done  = sel_b ? b_done : a_done;

  int checks = 0;
  int errors = 0;

  // Tile stimulus table and model-held completed-tile outputs.
  logic [14:0] tv    [8];
  logic [7:0]  tbytes[8][4];
  logic        tbg;
  logic [7:0]  exp_lo, exp_hi;
  logic [1:0]  exp_pal;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference address for fetch k of a tile, from the v field meanings.
  function automatic logic [13:0] model_addr(input logic [14:0] tvv, input logic tb,
                                             input logic [7:0] nt, input int k);
    int fine_y, ntsel, cy, cx, a;
    fine_y = int'(tvv) / 4096;
    ntsel  = (int'(tvv) / 1024) % 4;
    cy     = (int'(tvv) / 32) % 32;
    cx     = int'(tvv) % 32;
    case (k)
      0:       a = NT_BASE_I + ntsel * 1024 + cy * 32 + cx;
      1:       a = NT_BASE_I + 'h3C0 + ntsel * 1024 + (cy / 4) * 8 + cx / 4;
      2:       a = int'(tb) * 4096 + int'(nt) * 16 + fine_y;
      default: a = int'(tb) * 4096 + int'(nt) * 16 + 8 + fine_y;
    endcase
    return 14'(a);
  endfunction

  // Reference palette: quadrant index (0..3) selects a 2-bit field of the AT byte.
  function automatic logic [1:0] model_pal(input logic [14:0] tvv, input logic [7:0] at);
    int cy, cx, q;
    cy = (int'(tvv) / 32) % 32;
    cx = int'(tvv) % 32;
    q  = ((cy % 4) / 2) * 2 + (cx % 4) / 2;
    return 2'((int'(at) >> (2 * q)) % 4);
  endfunction

  task automatic check_held(input string tag);
    check({tag, "_lo"},  16'(obs_lo),  16'(exp_lo));
    check({tag, "_hi"},  16'(obs_hi),  16'(exp_hi));
    check({tag, "_pal"}, 16'(obs_pal), 16'(exp_pal));
  endtask

  task automatic complete(input int t);
    exp_lo  = tbytes[t][2];
    exp_hi  = tbytes[t][3];
    exp_pal = model_pal(tv[t], tbytes[t][1]);
  endtask

  // Runs n back-to-back tiles from the table; enable drops on the last
  // completion cycle, which must still complete.  i_v is scrambled mid-tile.
  task automatic run_tiles(input int n);
    int k;
    bg     = tbg;
    enable = 1'b1;
    v      = tv[0];
    for (int t = 0; t < n; t++) begin
      for (int c = 0; c < 4 * fc; c++) begin
        @(posedge clk); #1;
        k = c / fc;
        if (c == 0 && t > 0) complete(t - 1);
        check("addr",  16'(obs_addr),  16'(model_addr(tv[t], tbg, tbytes[t][0], k)));
        check("rd",    16'(obs_rd),    16'd1);
        check("fetch", 16'(obs_fetch), 16'(k));
        check("done",  16'(obs_done),  (c == 0 && t > 0) ? 16'd1 : 16'd0);
        check_held("hold");
        data = tbytes[t][k];
        if (c == 4 * fc - 1) begin
          if (t + 1 < n) v = tv[t + 1];
          else begin
            enable = 1'b0;
            v      = 15'($urandom);
          end
        end else begin
          v = 15'($urandom);
        end
      end
    end
    @(posedge clk); #1;
    complete(n - 1);
    $display("tile batch n=%0d fc=%0d last v=%h -> lo=%h hi=%h pal=%0d done=%0b",
             n, fc, tv[n - 1], obs_lo, obs_hi, obs_pal, obs_done);
    check("end_done",  16'(obs_done),  16'd1);
    check("end_rd",    16'(obs_rd),    16'd0);
    check("end_addr",  16'(obs_addr),  16'd0);
    check("end_fetch", 16'(obs_fetch), 16'd0);
    check_held("end");
    @(posedge clk); #1;
    check("pulse_one", 16'(obs_done), 16'd0);
    check_held("after");
  endtask

  task automatic fill_random(input int n);
    for (int t = 0; t < n; t++) begin
      tv[t] = 15'($urandom);
      for (int b = 0; b < 4; b++) tbytes[t][b] = 8'($urandom);
    end
    tbg = 1'($urandom);
  endtask

  task automatic set_req032();
    tv[0] = 15'h34AA; tbg = 1'b1;
    tbytes[0][0] = 8'h5C; tbytes[0][1] = 8'hE4;
    tbytes[0][2] = 8'hA5; tbytes[0][3] = 8'h3C;
  endtask

  task automatic pulse_reset();
    enable = 1'b0;
    rst_n  = 1'b0;
    @(posedge clk); #1;
    rst_n  = 1'b1;
    exp_lo = 8'h00; exp_hi = 8'h00; exp_pal = 2'd0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; v = '0; bg = 1'b0; data = '0;
    sel_b = 1'b0; fc = 2;
    exp_lo = 8'h00; exp_hi = 8'h00; exp_pal = 2'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr",  16'(obs_addr),  16'd0);
    check("rst_rd",    16'(obs_rd),    16'd0);
    check("rst_fetch", 16'(obs_fetch), 16'd0);
    check("rst_done",  16'(obs_done),  16'd0);
    check_held("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_rd", 16'(obs_rd), 16'd0);

    // Single directed tile, FETCH_CYCLES=2
    set_req032();
    run_tiles(1);
    check("req032_lo",  16'(obs_lo),  16'h00A5);
    check("req032_hi",  16'(obs_hi),  16'h003C);
    check("req032_pal", 16'(obs_pal), 16'd1);

    // Attribute quadrant select, four back-to-back tiles
    for (int q = 0; q < 4; q++) begin
      tv[q] = 15'($urandom);
      tv[q][6] = q[1];
      tv[q][1] = q[0];
      tbytes[q][0] = 8'($urandom); tbytes[q][1] = 8'hE4;
      tbytes[q][2] = 8'($urandom); tbytes[q][3] = 8'($urandom);
    end
    tbg = 1'b0;
    run_tiles(4);
    check("quad3_pal", 16'(obs_pal), 16'd3);

    // Random back-to-back batches
    for (int r = 0; r < 3; r++) begin
      fill_random(4);
      run_tiles(4);
    end

    // Abort during AT
    fill_random(1);
    enable = 1'b1; v = tv[0]; bg = tbg;
    for (int c = 0; c <= fc; c++) begin
      @(posedge clk); #1;
      data = 8'($urandom);
    end
    check("abort_in_at", 16'(obs_fetch), 16'd1);
    enable = 1'b0;
    @(posedge clk); #1;
    $display("abort in AT: rd=%0b addr=%h done=%0b", obs_rd, obs_addr, obs_done);
    check("abort_rd",    16'(obs_rd),    16'd0);
    check("abort_addr",  16'(obs_addr),  16'd0);
    check("abort_fetch", 16'(obs_fetch), 16'd0);
    check("abort_done",  16'(obs_done),  16'd0);
    check_held("abort");
    @(posedge clk); #1;
    check("abort_done2", 16'(obs_done), 16'd0);
    check_held("abort2");

    // Reset in the middle of PT_LO, then a clean directed tile
    fill_random(1);
    enable = 1'b1; v = tv[0]; bg = tbg;
    for (int c = 0; c <= 2 * fc; c++) begin
      @(posedge clk); #1;
      data = 8'($urandom);
    end
    check("mid_ptlo", 16'(obs_fetch), 16'd2);
    rst_n = 1'b0;
    #2;
    exp_lo = 8'h00; exp_hi = 8'h00; exp_pal = 2'd0;
    $display("async reset in PT_LO: addr=%h rd=%0b lo=%h hi=%h", obs_addr, obs_rd, obs_lo, obs_hi);
    check("arst_addr",  16'(obs_addr),  16'd0);
    check("arst_rd",    16'(obs_rd),    16'd0);
    check("arst_fetch", 16'(obs_fetch), 16'd0);
    check("arst_done",  16'(obs_done),  16'd0);
    check_held("arst");
    enable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_req032();
    run_tiles(1);

    // FETCH_CYCLES=1 instance
    sel_b = 1'b1; fc = 1;
    pulse_reset();
    check("b_rst_done", 16'(obs_done), 16'd0);
    check_held("b_rst");
    tv[0] = 15'h0000; tbg = 1'b0;
    tbytes[0][0] = 8'hFF; tbytes[0][1] = 8'($urandom);
    tbytes[0][2] = 8'($urandom); tbytes[0][3] = 8'($urandom);
    run_tiles(1);
    fill_random(4);
    run_tiles(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
